// File: rtl/move_path_stack.sv
// Move-path LIFO for the puzzle search engine: 2-bit direction codes packed into
// ord, with inverse-move pruning, depth limiting and a freeze-on-solved DONE state.
module move_path_stack #(
  parameter int MAX_DEPTH = 22,
  parameter int CNT_W     = 26,
  parameter int LIM_W     = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [LIM_W-1:0]       depth_limit,
  input  logic                   push_valid,
  input  logic [1:0]             push_dir,
  output logic                   push_ready,
  input  logic                   pop_req,
  output logic                   pop_ack,
  output logic [1:0]             pop_dir,
  input  logic                   solved,
  output logic [2*MAX_DEPTH-1:0] ord,
  output logic [CNT_W-1:0]       cnt,
  output logic                   comp,
  output logic                   full,
  output logic [1:0]             err
);

  localparam int DW = $clog2(MAX_DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'b00, SEARCH = 2'b01, DONE = 2'b10} state_t;

  state_t        state;
  logic [DW-1:0] depth;
  logic [DW-1:0] eff_limit;
  logic [31:0]   lim_ext;
  logic [1:0]    top_dir;
  logic          at_limit;
  logic          is_inverse;

  assign lim_ext   = 32'(depth_limit);
  assign eff_limit = (lim_ext > 32'(MAX_DEPTH)) ? DW'(MAX_DEPTH) : DW'(depth_limit);

  // Most recent move, read straight from the packed word so it tracks depth in the same cycle.
  always_comb begin
    top_dir = 2'b00;
    for (int k = 0; k < MAX_DEPTH; k++)
      if (int'(depth) == k + 1) top_dir = ord[2*k +: 2];
  end

  // >= rather than == so a limit lowered under the current depth still reads as full.
  assign at_limit   = (depth >= eff_limit);
  assign is_inverse = (depth != '0) && (push_dir == (top_dir ^ 2'b10));
  assign push_ready = (state == SEARCH) && !pop_req && !solved && !at_limit && !is_inverse;
  assign full       = at_limit;
  assign cnt        = CNT_W'(depth);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ord     <= '0;
      depth   <= '0;
      comp    <= 1'b0;
      pop_ack <= 1'b0;
      pop_dir <= 2'b00;
      err     <= 2'b00;
    end else begin
      pop_ack <= 1'b0;
      if (start) begin
        state <= SEARCH;
        ord   <= '0;
        depth <= '0;
        comp  <= 1'b0;
        err   <= 2'b00;
      end else begin
        case (state)
          SEARCH: begin
            if (push_valid && at_limit) err[1] <= 1'b1;
            if (pop_req && depth == '0) err[0] <= 1'b1;
            // solved outranks pop, pop outranks push
            if (solved) begin
              state <= DONE;
              comp  <= 1'b1;
            end else if (pop_req && depth != '0) begin
              ord[2*(int'(depth)-1) +: 2] <= 2'b00;
              depth   <= depth - DW'(1);
              pop_dir <= top_dir;
              pop_ack <= 1'b1;
            end else if (push_valid && push_ready) begin
              ord[2*int'(depth) +: 2] <= push_dir;
              depth <= depth + DW'(1);
            end
          end
          IDLE, DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_path_stack.sv
// Bench for move_path_stack: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the move path.
module tb_move_path_stack;
  localparam int MD = 22;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, start = 1'b0, push_valid = 1'b0, pop_req = 1'b0, solved = 1'b0;
  logic [4:0]  depth_limit = 5'd22;
  logic [1:0]  push_dir = 2'b00;
  logic        push_ready, pop_ack, comp, full;
  logic [1:0]  pop_dir, err;
  logic [43:0] ord;
  logic [25:0] cnt;

  always #5 clk = ~clk;

  move_path_stack #(.MAX_DEPTH(MD), .CNT_W(26), .LIM_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .depth_limit(depth_limit),
    .push_valid(push_valid), .push_dir(push_dir), .push_ready(push_ready),
    .pop_req(pop_req), .pop_ack(pop_ack), .pop_dir(pop_dir), .solved(solved),
    .ord(ord), .cnt(cnt), .comp(comp), .full(full), .err(err)
  );

  int checks = 0, errors = 0;

  // model: path as a queue, state 0=idle 1=search 2=done
  int       path[$];
  int       mstate = 0;
  bit       mcomp = 0, mack = 0, chk_en = 0;
  bit [1:0] mdir = 0, merr = 0;

  function automatic int eff();
    return (int'(depth_limit) > MD) ? MD : int'(depth_limit);
  endfunction

  function automatic bit mready();
    if (mstate != 1 || pop_req || solved) return 0;
    if (path.size() >= eff()) return 0;
    if (path.size() > 0 && int'(push_dir) == (path[$] ^ 2)) return 0;
    return 1;
  endfunction

  function automatic logic [43:0] mord();
    logic [43:0] o;
    o = '0;
    foreach (path[k]) o[2*k +: 2] = 2'(path[k]);
    return o;
  endfunction

  task automatic model_step();
    bit rdy;
    rdy  = mready();
    mack = 0;
    if (!rst_n) begin
      path.delete(); mstate = 0; mcomp = 0; mdir = 0; merr = 0;
    end else if (start) begin
      path.delete(); mstate = 1; mcomp = 0; merr = 0;
    end else if (mstate == 1) begin
      if (push_valid && path.size() >= eff()) merr[1] = 1;
      if (pop_req && path.size() == 0) merr[0] = 1;
      if (solved) begin
        mstate = 2; mcomp = 1;
      end else if (pop_req && path.size() > 0) begin
        mdir = 2'(path.pop_back()); mack = 1;
      end else if (push_valid && rdy) begin
        path.push_back(int'(push_dir));
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ord", 64'(ord), 64'(mord()));
      chk("cnt", 64'(cnt), 64'(path.size()));
      chk("comp", 64'(comp), 64'(mcomp));
      chk("full", 64'(full), 64'(path.size() >= eff()));
      chk("err", 64'(err), 64'(merr));
      chk("pop_ack", 64'(pop_ack), 64'(mack));
      chk("pop_dir", 64'(pop_dir), 64'(mdir));
      chk("push_ready", 64'(push_ready), 64'(mready()));
    end
  end

  // Advance one edge (model follows the inputs held across it), then drive the next inputs.
  task automatic cyc(input bit r, input bit st, input bit pv, input bit [1:0] pd,
                     input bit pr, input bit sv);
    @(posedge clk);
    model_step();
    chk_en = 1;
    #1;
    rst_n = r; start = st; push_valid = pv; push_dir = pd; pop_req = pr; solved = sv;
  endtask

  task automatic idle();               cyc(1, 0, 0, 2'd0, 0, 0); endtask
  task automatic push(input bit [1:0] d); cyc(1, 0, 1, d, 0, 0);    endtask
  task automatic pop();                cyc(1, 0, 0, 2'd0, 1, 0); endtask
  task automatic go();                 cyc(1, 1, 0, 2'd0, 0, 0); endtask

  initial begin
    cyc(0, 0, 0, 2'd0, 0, 0);
    go();
    chk("rst_ord", 64'(ord), 64'h0);
    chk("rst_cnt", 64'(cnt), 64'h0);
    chk("rst_comp", 64'(comp), 64'h0);

    // 1: UP, RIGHT, UP then solved; path freezes
    push(2'd1); push(2'd2); push(2'd1); cyc(1, 0, 0, 2'd0, 0, 1); idle();
    chk("t1_ord", 64'(ord), 64'h19);
    chk("t1_cnt", 64'(cnt), 64'd3);
    chk("t1_comp", 64'(comp), 64'd1);
    push(2'd0); pop(); idle();
    chk("t1_frozen_ord", 64'(ord), 64'h19);
    chk("t1_frozen_cnt", 64'(cnt), 64'd3);

    // 2: inverse pruning
    go(); push(2'd1); push(2'd3); idle();
    chk("t2_pruned_cnt", 64'(cnt), 64'd1);
    chk("t2_pruned_err", 64'(err), 64'd0);
    push(2'd0); idle();
    chk("t2_cnt", 64'(cnt), 64'd2);
    chk("t2_ord", 64'(ord), 64'h1);

    // 3: pops and pop on empty
    go(); push(2'd0); push(2'd1); push(2'd2); pop(); idle();
    chk("t3_ack", 64'(pop_ack), 64'd1);
    chk("t3_dir", 64'(pop_dir), 64'd2);
    chk("t3_cnt", 64'(cnt), 64'd2);
    chk("t3_ord", 64'(ord), 64'h4);
    pop(); pop(); idle(); pop(); idle();
    chk("t3_empty_err", 64'(err), 64'd1);
    chk("t3_empty_cnt", 64'(cnt), 64'd0);
    chk("t3_empty_ack", 64'(pop_ack), 64'd0);

    // 4: depth limit, then clamp of 31 to 22
    depth_limit = 5'd3;
    go(); push(2'd1); push(2'd1); push(2'd1); idle();
    chk("t4_full", 64'(full), 64'd1);
    push(2'd1); idle();
    chk("t4_err", 64'(err), 64'd2);
    chk("t4_cnt", 64'(cnt), 64'd3);
    depth_limit = 5'd31;
    repeat (18) push(2'd1);
    push(2'd2); idle();
    chk("t4_cnt22", 64'(cnt), 64'd22);
    chk("t4_full22", 64'(full), 64'd1);
    chk("t4_last", 64'(ord[43:42]), 64'd2);

    // 5: same-cycle priorities
    go(); push(2'd1); cyc(1, 0, 1, 2'd0, 1, 0); idle();
    chk("t5_pop_cnt", 64'(cnt), 64'd0);
    chk("t5_pop_dir", 64'(pop_dir), 64'd1);
    push(2'd2); cyc(1, 0, 1, 2'd2, 0, 1); idle();
    chk("t5_solved_cnt", 64'(cnt), 64'd1);
    chk("t5_solved_comp", 64'(comp), 64'd1);
    cyc(1, 1, 0, 2'd0, 0, 1); idle();
    chk("t5_start_comp", 64'(comp), 64'd0);
    chk("t5_start_cnt", 64'(cnt), 64'd0);

    // 6: reset mid-search
    repeat (5) push(2'd1);
    cyc(0, 0, 0, 2'd0, 0, 0);
    chk("t6_pre_cnt", 64'(cnt), 64'd5);
    idle();
    chk("t6_ord", 64'(ord), 64'h0);
    chk("t6_cnt", 64'(cnt), 64'd0);
    chk("t6_err", 64'(err), 64'd0);
    chk("t6_ready", 64'(push_ready), 64'd0);
    push(2'd1); idle();
    chk("t6_idle_cnt", 64'(cnt), 64'd0);

    // random traffic
    go();
    repeat (3000) begin
      if ($urandom_range(0, 19) == 0) depth_limit = 5'($urandom_range(0, 31));
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 49) == 0,
          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
    end
    idle(); idle();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
